// File: rtl/srt4_pkg.sv
// Shared types and constants for the radix-4 SRT divider control sequencer.
package srt4_pkg;

    localparam int unsigned W      = 8;
    localparam int unsigned N_ITER = W / 2;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StZchk,
        StNorm,
        StIterSh,
        StIterAdd,
        StCorr,
        StConv,
        StDenorm,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        DigM2,
        DigM1,
        DigZ,
        DigP1,
        DigP2
    } digit_e;

    // Lower bound of the estimate window for each digit, as a signed 4-bit value.
    localparam logic signed [3:0] TH_P2 = 4'sd3;
    localparam logic signed [3:0] TH_P1 = 4'sd1;
    localparam logic signed [3:0] TH_Z  = -4'sd1;
    localparam logic signed [3:0] TH_M1 = -4'sd3;

endpackage

// File: rtl/srt4_qsel.sv
// Quotient digit selection: maps the signed P estimate window to a radix-4 digit.
module srt4_qsel
    import srt4_pkg::*;
(
    input  logic [3:0] p_est,
    output digit_e     digit
);

    logic signed [3:0] t;

    always_comb begin
        t = signed'(p_est);
        if (t >= TH_P2) begin
            digit = DigP2;
        end else if (t >= TH_P1) begin
            digit = DigP1;
        end else if (t >= TH_Z) begin
            digit = DigZ;
        end else if (t >= TH_M1) begin
            digit = DigM1;
        end else begin
            digit = DigM2;
        end
    end

endmodule

// File: rtl/srt4_control.sv
// Control sequencer for the radix-4 SRT divider; issues registered c0..c14 pulses,
// each followed by a settle cycle before any datapath status is sampled.
module srt4_control
    import srt4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       b_msb,
    input  logic       b_zero,
    input  logic [3:0] p_est,
    input  logic       p_sign,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       c8,
    output logic       c9,
    output logic       c10,
    output logic       c11,
    output logic       c12,
    output logic       c13,
    output logic       c14,
    output logic       busy,
    output logic       done,
    output logic       div_err
);

    localparam int unsigned IT_W = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] NORM_MAX = CNT_W'(W - 1);
    localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(N_ITER - 1);

    state_e            state_q, state_d;
    logic              phase_q, phase_d;   // 0: decide/settle cycle, 1: pulse cycle
    logic [14:0]       c_q, c_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_err_q, div_err_d;
    logic [CNT_W-1:0]  norm_cnt_q, norm_cnt_d;
    logic [IT_W-1:0]   it_cnt_q, it_cnt_d;
    digit_e            digit_q, digit_d;
    digit_e            digit;

    srt4_qsel u_qsel (
        .p_est (p_est),
        .digit (digit)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = 1'b0;
        c_d        = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_err_d  = div_err_q;
        norm_cnt_d = norm_cnt_q;
        it_cnt_d   = it_cnt_q;
        digit_d    = digit_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    busy_d    = 1'b1;
                    div_err_d = 1'b0;
                end
            end
            StLoad: begin
                if (!phase_q) begin
                    c_d[0]     = 1'b1;
                    c_d[1]     = 1'b1;
                    norm_cnt_d = '0;
                    phase_d    = 1'b1;
                end else begin
                    state_d = StZchk;
                end
            end
            StZchk: begin
                if (b_zero) begin
                    div_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (!phase_q) begin
                    if (!b_msb) begin
                        c_d[2]  = 1'b1;
                        phase_d = 1'b1;
                        if (norm_cnt_q != NORM_MAX) begin
                            norm_cnt_d = norm_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d  = StIterSh;
                        it_cnt_d = '0;
                    end
                end
            end
            StIterSh: begin
                if (!phase_q) begin
                    digit_d = digit;
                    c_d[3]  = 1'b1;
                    c_d[4]  = (digit == DigP1);
                    c_d[5]  = (digit == DigM1);
                    c_d[6]  = (digit == DigM2);
                    c_d[7]  = (digit == DigP2);
                    phase_d = 1'b1;
                end else if (digit_q != DigZ) begin
                    state_d = StIterAdd;
                end else begin
                    it_cnt_d = it_cnt_q + 1'b1;
                    state_d  = (it_cnt_q == IT_LAST) ? StCorr : StIterSh;
                end
            end
            StIterAdd: begin
                if (!phase_q) begin
                    c_d[8]  = 1'b1;
                    c_d[9]  = (digit_q == DigP2) || (digit_q == DigM2);
                    c_d[10] = (digit_q == DigP2) || (digit_q == DigP1);
                    phase_d = 1'b1;
                end else begin
                    it_cnt_d = it_cnt_q + 1'b1;
                    state_d  = (it_cnt_q == IT_LAST) ? StCorr : StIterSh;
                end
            end
            StCorr: begin
                if (!phase_q) begin
                    if (p_sign) begin
                        c_d[8]  = 1'b1;
                        c_d[11] = 1'b1;
                        c_d[12] = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        state_d = StConv;
                    end
                end else begin
                    state_d = StConv;
                end
            end
            StConv: begin
                if (!phase_q) begin
                    c_d[13] = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    state_d = StDenorm;
                end
            end
            StDenorm: begin
                if (!phase_q) begin
                    if (norm_cnt_q != '0) begin
                        c_d[14]    = 1'b1;
                        norm_cnt_d = norm_cnt_q - 1'b1;
                        phase_d    = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!phase_q) begin
                    done_d  = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            c_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_err_q  <= 1'b0;
            norm_cnt_q <= '0;
            it_cnt_q   <= '0;
            digit_q    <= DigZ;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            c_q        <= c_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_err_q  <= div_err_d;
            norm_cnt_q <= norm_cnt_d;
            it_cnt_q   <= it_cnt_d;
            digit_q    <= digit_d;
        end
    end

    assign c0      = c_q[0];
    assign c1      = c_q[1];
    assign c2      = c_q[2];
    assign c3      = c_q[3];
    assign c4      = c_q[4];
    assign c5      = c_q[5];
    assign c6      = c_q[6];
    assign c7      = c_q[7];
    assign c8      = c_q[8];
    assign c9      = c_q[9];
    assign c10     = c_q[10];
    assign c11     = c_q[11];
    assign c12     = c_q[12];
    assign c13     = c_q[13];
    assign c14     = c_q[14];
    assign busy    = busy_q;
    assign done    = done_q;
    assign div_err = div_err_q;

endmodule
